clk_rst_sequencer: RTL and testbench
====================================

// Module: clk_rst_sequencer
// PURPOSE
//  Sequences the 2x clock generator after board reset: pulses its reset, waits for
//  lock, qualifies lock stability, then releases a system reset and clock enable.
//  Handles lock timeout with retry, lock loss during operation and software resets.
//  Sits in the clk_in1 domain between board reset and the clock generator/core reset tree.
// PARAMETERS
//  PLL_RST_CYCLES  4      clk_in1 cycles pll_resetn is held low per attempt (>=1)
//  LOCK_TIMEOUT    1000   max cycles in WAIT_LOCK before retrying (>=2)
//  STABLE_CYCLES   64     consecutive synced-lock cycles required before RUN (>=1)
//  SYS_RST_CYCLES  16     sys_resetn low time for a software reset (>=1)
//  CNT_W           16     width of shared cycle counter; must hold every count above
//  MAX_RETRIES     8      timeout retries before FAIL (only with RETRY_LIMIT_EN)
// PORTS
//  clk_in1      in   1  100 MHz reference clock
//  resetn       in   1  board reset
//  pll_locked   in   1  lock from clock generator, asynchronous to clk_in1
//  soft_rst_req in   1  single-cycle software reset request
//  err_clr      in   1  clears lock_err
//  pll_resetn   out  1  active-low reset to clock generator
//  sys_resetn   out  1  active-low system reset
//  clk_en       out  1  downstream clock enable
//  lock_err     out  1  sticky: lock lost while in RUN/SOFT_RST
//  retry_cnt    out  8  lock-timeout count, saturates at 255
//  fail         out  1  retry limit exhausted (0 when RETRY_LIMIT_EN undefined)
//  state_o      out  3  current state encoding
// BEHAVIOUR
//  - Reset resetn, asynchronous, active-low; clock clk_in1. In reset: state RST_PLL,
//    pll_resetn=0, sys_resetn=0, clk_en=0, lock_err=0, retry_cnt=0, fail=0, counter=0.
//  - pll_locked passes a 2-flop synchronizer (lk_s); FSM sees edges 2 cycles late.
//  - All outputs registered, decoded from next state: they change in the same cycle
//    state_o changes.
//  - States: RST_PLL=0 WAIT_LOCK=1 STABLE=2 RUN=3 SOFT_RST=4 FAIL=5.
//  - RST_PLL: pll_resetn=0; after PLL_RST_CYCLES cycles -> WAIT_LOCK, counter=0.
//  - WAIT_LOCK: pll_resetn=1. lk_s=1 -> STABLE, counter=0. Else at counter==LOCK_TIMEOUT-1
//    -> RST_PLL, retry_cnt+1 (saturating).
//  - STABLE: lk_s=0 -> WAIT_LOCK, counter=0, no retry increment. STABLE_CYCLES
//    consecutive lk_s=1 -> RUN.
//  - RUN: sys_resetn=1, clk_en=1, retry_cnt held. soft_rst_req=1 -> SOFT_RST, counter=0.
//  - SOFT_RST: sys_resetn=0, clk_en=1; after SYS_RST_CYCLES -> RUN. Requests ignored here
//    and in all non-RUN states (no queuing).
//  - Lock loss: lk_s=0 in RUN or SOFT_RST -> RST_PLL, lock_err=1, sys_resetn=0, clk_en=0
//    same cycle. Lock loss beats simultaneous soft_rst_req.
//  - lock_err cleared by err_clr; lock_err set event beats simultaneous err_clr.
//  - Counter cleared on every state transition; never wraps (compare stops it).
//  - resetn asserted in any state -> immediate async return to reset values.
// CONFIGURATION
//  RETRY_LIMIT_EN defined: on timeout with retry_cnt==MAX_RETRIES-1, go to FAIL instead
//    of RST_PLL; FAIL holds pll_resetn=0, sys_resetn=0, clk_en=0, fail=1 until resetn.
//  RETRY_LIMIT_EN undefined: retries forever; FAIL unreachable; fail tied 0.
// TESTING (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, SYS_RST_CYCLES=6)
//  1 Release resetn, pll_locked=1 at cycle 10 -> pll_resetn high cycles 4+; RUN,
//    sys_resetn=1, clk_en=1 reached 2+8 cycles after lk_s path; lock_err=0, retry_cnt=0.
//  2 pll_locked held 0 -> WAIT_LOCK times out every 24 cycles, pll_resetn low 4 cycles,
//    retry_cnt 1,2,3...; sys_resetn stays 0.
//  3 In STABLE drop pll_locked for 1 cycle at count 5 -> back to WAIT_LOCK, full 8 cycles
//    required again, retry_cnt unchanged.
//  4 In RUN pulse soft_rst_req -> sys_resetn 0 for exactly 6 cycles, clk_en stays 1;
//    second pulse during SOFT_RST ignored.
//  5 In RUN drop pll_locked with soft_rst_req same cycle -> RST_PLL, lock_err=1, clk_en=0;
//    err_clr pulse later -> lock_err=0.
//  6 RETRY_LIMIT_EN, MAX_RETRIES=3, pll_locked=0 -> FAIL after 3rd timeout, fail=1;
//    assert resetn mid-FAIL -> all outputs to reset values immediately.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
// Power-up sequencer for the 2x clock generator: PLL reset pulse, lock wait/qualify, system reset release.
// Optional macro RETRY_LIMIT_EN bounds lock-timeout retries (MAX_RETRIES) and parks in FAIL.
module clk_rst_sequencer #(
`ifdef RETRY_LIMIT_EN
    parameter int MAX_RETRIES    = 8,
`endif
    parameter int PLL_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 1000,
    parameter int STABLE_CYCLES  = 64,
    parameter int SYS_RST_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic       clk_in1,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    input  logic       err_clr,
    output logic       pll_resetn,
    output logic       sys_resetn,
    output logic       clk_en,
    output logic       lock_err,
    output logic [7:0] retry_cnt,
    output logic       fail,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT_RST  = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lk_s1;
    logic             lk_s;
    logic             retry_inc;
    logic             loss;

    // pll_locked comes from another clock domain
    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            lk_s1 <= 1'b0;
            lk_s  <= 1'b0;
        end else begin
            lk_s1 <= pll_locked;
            lk_s  <= lk_s1;
        end
    end

    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt;
        retry_inc = 1'b0;
        loss      = 1'b0;
        case (state)
            ST_RST_PLL: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_W'(PLL_RST_CYCLES - 1))
                    nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                cnt_nxt = cnt + 1'b1;
                if (lk_s) begin
                    nxt = ST_STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_inc = 1'b1;
                    nxt       = ST_RST_PLL;
`ifdef RETRY_LIMIT_EN
                    if (retry_cnt == 8'(MAX_RETRIES - 1))
                        nxt = ST_FAIL;
`endif
                end
            end
            ST_STABLE: begin
                cnt_nxt = cnt + 1'b1;
                if (!lk_s)
                    nxt = ST_WAIT_LOCK;
                else if (cnt == CNT_W'(STABLE_CYCLES - 1))
                    nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!lk_s) begin
                    loss = 1'b1;
                    nxt  = ST_RST_PLL;
                end else if (soft_rst_req) begin
                    nxt = ST_SOFT_RST;
                end
            end
            ST_SOFT_RST: begin
                cnt_nxt = cnt + 1'b1;
                if (!lk_s) begin
                    loss = 1'b1;
                    nxt  = ST_RST_PLL;
                end else if (cnt == CNT_W'(SYS_RST_CYCLES - 1)) begin
                    nxt = ST_RUN;
                end
            end
`ifdef RETRY_LIMIT_EN
            ST_FAIL: nxt = ST_FAIL;
`endif
            default: nxt = ST_RST_PLL;
        endcase
        // Every transition restarts the shared counter
        if (nxt != state)
            cnt_nxt = '0;
    end

    // Outputs decode the next state so they move together with state_o
    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_RST_PLL;
            cnt        <= '0;
            pll_resetn <= 1'b0;
            sys_resetn <= 1'b0;
            clk_en     <= 1'b0;
            lock_err   <= 1'b0;
            retry_cnt  <= 8'd0;
            state_o    <= 3'd0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nxt;
            pll_resetn <= (nxt != ST_RST_PLL) && (nxt != ST_FAIL);
            sys_resetn <= (nxt == ST_RUN);
            clk_en     <= (nxt == ST_RUN) || (nxt == ST_SOFT_RST);
            state_o    <= nxt;
            if (loss)
                lock_err <= 1'b1;
            else if (err_clr)
                lock_err <= 1'b0;
            if (retry_inc && (retry_cnt != 8'hFF))
                retry_cnt <= retry_cnt + 8'd1;
        end
    end

`ifdef RETRY_LIMIT_EN
    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn)
            fail <= 1'b0;
        else
            fail <= (nxt == ST_FAIL);
    end
`else
    assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with short timing parameters; FAIL path covered when RETRY_LIMIT_EN is defined.
module tb_clk_rst_sequencer;

    logic       clk_in1 = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       err_clr = 1'b0;
    logic       pll_resetn;
    logic       sys_resetn;
    logic       clk_en;
    logic       lock_err;
    logic [7:0] retry_cnt;
    logic       fail;
    logic [2:0] state_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_in1 = ~clk_in1;

    clk_rst_sequencer #(
`ifdef RETRY_LIMIT_EN
        .MAX_RETRIES    (3),
`endif
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .SYS_RST_CYCLES (6),
        .CNT_W          (16)
    ) dut (
        .clk_in1      (clk_in1),
        .resetn       (resetn),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .err_clr      (err_clr),
        .pll_resetn   (pll_resetn),
        .sys_resetn   (sys_resetn),
        .clk_en       (clk_en),
        .lock_err     (lock_err),
        .retry_cnt    (retry_cnt),
        .fail         (fail),
        .state_o      (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int pr, input int sr, input int ce);
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".pll_resetn"}, 32'(pll_resetn), 32'(pr));
        check({tag, ".sys_resetn"}, 32'(sys_resetn), 32'(sr));
        check({tag, ".clk_en"}, 32'(clk_en), 32'(ce));
    endtask

    task automatic check_reset_vals(input string tag);
        check_outs(tag, 0, 0, 0, 0);
        check({tag, ".lock_err"}, 32'(lock_err), 0);
        check({tag, ".retry_cnt"}, 32'(retry_cnt), 0);
        check({tag, ".fail"}, 32'(fail), 0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in1);
            #1;
        end
    endtask

    initial begin
        #12;
        check_reset_vals("reset");
        @(posedge clk_in1);
        #1;
        resetn = 1'b1;

        // Power-up: 4 cycles of PLL reset, then lock through the synchronizer and 8 stable cycles
        step(3);
        check_outs("t1_rst_pll", 0, 0, 0, 0);
        step(1);
        check_outs("t1_wait", 1, 1, 0, 0);
        pll_locked = 1'b1;
        step(2);
        check("t1_sync_delay", 32'(state_o), 1);
        step(1);
        check("t1_stable", 32'(state_o), 2);
        step(7);
        check_outs("t1_stable_end", 2, 1, 0, 0);
        step(1);
        check_outs("t1_run", 3, 1, 1, 1);
        check("t1_lock_err", 32'(lock_err), 0);
        check("t1_retry", 32'(retry_cnt), 0);

        // Software reset: 6 cycles low, a second request inside is dropped
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        check_outs("t4_soft", 4, 1, 0, 1);
        step(2);
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        check("t4_soft_c4", 32'(state_o), 4);
        step(2);
        check_outs("t4_soft_c6", 4, 1, 0, 1);
        step(1);
        check_outs("t4_back_run", 3, 1, 1, 1);
        step(3);
        check("t4_no_queue", 32'(state_o), 3);

        // Lock loss with simultaneous soft request and err_clr: loss wins both
        pll_locked = 1'b0;
        step(2);
        check("t5_run_sync", 32'(state_o), 3);
        soft_rst_req = 1'b1;
        err_clr = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        err_clr = 1'b0;
        check_outs("t5_loss", 0, 0, 0, 0);
        check("t5_lock_err_set", 32'(lock_err), 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("t5_lock_err_clr", 32'(lock_err), 0);
        step(3);
        check("t3_wait", 32'(state_o), 1);

        // One-cycle lock glitch in STABLE restarts qualification without a retry
        pll_locked = 1'b1;
        step(3);
        check("t3_stable", 32'(state_o), 2);
        step(2);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        check("t3_still_stable", 32'(state_o), 2);
        step(1);
        check("t3_back_wait", 32'(state_o), 1);
        check("t3_retry", 32'(retry_cnt), 0);
        step(1);
        check("t3_restable", 32'(state_o), 2);
        step(7);
        check("t3_full_again", 32'(state_o), 2);
        step(1);
        check_outs("t3_run", 3, 1, 1, 1);

        // Lock held low: timeout every 24 cycles
        pll_locked = 1'b0;
        step(2);
        check("t2_run_sync", 32'(state_o), 3);
        step(1);
        check_outs("t2_loss", 0, 0, 0, 0);
        check("t2_lock_err", 32'(lock_err), 1);
        step(4);
        check_outs("t2_wait1", 1, 1, 0, 0);
        step(19);
        check("t2_wait1_end", 32'(state_o), 1);
        step(1);
        check_outs("t2_to1", 0, 0, 0, 0);
        check("t2_retry1", 32'(retry_cnt), 1);
        step(3);
        check("t2_rst_hold", 32'(state_o), 0);
        step(1);
        check_outs("t2_wait2", 1, 1, 0, 0);
        step(19);
        check("t2_wait2_end", 32'(state_o), 1);
        step(1);
        check_outs("t2_to2", 0, 0, 0, 0);
        check("t2_retry2", 32'(retry_cnt), 2);
        step(4);
        check("t2_wait3", 32'(state_o), 1);
        step(19);
        check("t2_wait3_end", 32'(retry_cnt), 2);
        step(1);
`ifdef RETRY_LIMIT_EN
        check_outs("t6_fail", 5, 0, 0, 0);
        check("t6_fail_flag", 32'(fail), 1);
        check("t6_retry3", 32'(retry_cnt), 3);
        step(5);
        check("t6_fail_hold", 32'(state_o), 5);
        check("t6_fail_flag_hold", 32'(fail), 1);
`else
        check_outs("t2_to3", 0, 0, 0, 0);
        check("t2_retry3", 32'(retry_cnt), 3);
        check("t2_fail_tied", 32'(fail), 0);
        step(6);
        check("t2_wait4", 32'(state_o), 1);
`endif
        // Asynchronous reset between clock edges
        #2;
        resetn = 1'b0;
        #1;
        check_reset_vals("async_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
